// File: rtl/title_banner_animator.sv
// Title-screen banner sequencer: slides the banner in, bounces it while blinking
// the prompt, exits upward on a start press, then pulses title_done.
module title_banner_animator #(
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned BANNER_W_PX  = 320,
   parameter int unsigned X_MARGIN     = 40,
   parameter int unsigned X_START      = 160,
   parameter int unsigned START_Y      = 0,
   parameter int unsigned REST_Y       = 120,
   parameter int unsigned STEP_Y       = 2,
   parameter int unsigned STEP_EXIT    = 4,
   parameter int unsigned HOVER_DIV    = 2,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_btn,
   output logic [9:0] origin_x,
   output logic [9:0] origin_y,
   output logic       banner_visible,
   output logic       prompt_visible,
   output logic       title_done
);

   localparam int unsigned COORD_W = 10;
   localparam int unsigned SUM_W   = COORD_W + 1;
   localparam int unsigned X_MIN   = X_MARGIN;
   localparam int unsigned X_MAX   = SCREEN_W - BANNER_W_PX - X_MARGIN;
   localparam int unsigned DIV_W   = (HOVER_DIV > 1) ? $clog2(HOVER_DIV) : 1;
   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic [1:0] {
      S_SLIDE_IN = 2'd0,
      S_HOVER    = 2'd1,
      S_EXIT     = 2'd2,
      S_DONE     = 2'd3
   } state_e;

   state_e               state_q;
   logic [COORD_W-1:0]   origin_x_q;
   logic [COORD_W-1:0]   origin_y_q;
   logic                 banner_visible_q;
   logic                 prompt_visible_q;
   logic                 title_done_q;
   logic                 dir_right_q;
   logic [DIV_W-1:0]     div_cnt_q;
   logic [BLINK_W-1:0]   blink_cnt_q;
   logic                 start_q;

   logic                 start_edge;
   logic [SUM_W-1:0]     slide_sum;

   assign start_edge = start_btn & ~start_q;
   assign slide_sum  = {1'b0, origin_y_q} + SUM_W'(STEP_Y);

   // Sequencer; every position and flag update happens here so outputs stay registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_SLIDE_IN;
         origin_x_q       <= COORD_W'(X_START);
         origin_y_q       <= COORD_W'(START_Y);
         banner_visible_q <= 1'b1;
         prompt_visible_q <= 1'b0;
         title_done_q     <= 1'b0;
         dir_right_q      <= 1'b1;
         div_cnt_q        <= '0;
         blink_cnt_q      <= '0;
         start_q          <= 1'b1;
      end else begin
         start_q      <= start_btn;
         title_done_q <= 1'b0;
         case (state_q)
            S_SLIDE_IN: begin
               if (start_edge) begin
                  state_q <= S_EXIT;
               end else if (frame_tick) begin
                  if (slide_sum >= SUM_W'(REST_Y)) begin
                     origin_y_q       <= COORD_W'(REST_Y);
                     state_q          <= S_HOVER;
                     prompt_visible_q <= 1'b1;
                     blink_cnt_q      <= '0;
                     div_cnt_q        <= '0;
                  end else begin
                     origin_y_q <= slide_sum[COORD_W-1:0];
                  end
               end
            end
            S_HOVER: begin
               if (start_edge) begin
                  // A start press beats a coincident frame_tick: origin is held.
                  state_q          <= S_EXIT;
                  prompt_visible_q <= 1'b0;
               end else if (frame_tick) begin
                  if (div_cnt_q == DIV_W'(HOVER_DIV - 1)) begin
                     div_cnt_q <= '0;
                     if (dir_right_q) begin
                        if (origin_x_q == COORD_W'(X_MAX)) begin
                           dir_right_q <= 1'b0;
                           origin_x_q  <= COORD_W'(X_MAX - 1);
                        end else begin
                           origin_x_q <= origin_x_q + COORD_W'(1);
                        end
                     end else begin
                        if (origin_x_q == COORD_W'(X_MIN)) begin
                           dir_right_q <= 1'b1;
                           origin_x_q  <= COORD_W'(X_MIN + 1);
                        end else begin
                           origin_x_q <= origin_x_q - COORD_W'(1);
                        end
                     end
                  end else begin
                     div_cnt_q <= div_cnt_q + DIV_W'(1);
                  end
                  if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                     blink_cnt_q      <= '0;
                     prompt_visible_q <= ~prompt_visible_q;
                  end else begin
                     blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                  end
               end
            end
            S_EXIT: begin
               if (frame_tick) begin
                  if (origin_y_q <= COORD_W'(STEP_EXIT)) begin
                     origin_y_q       <= '0;
                     state_q          <= S_DONE;
                     banner_visible_q <= 1'b0;
                     title_done_q     <= 1'b1;
                  end else begin
                     origin_y_q <= origin_y_q - COORD_W'(STEP_EXIT);
                  end
               end
            end
            S_DONE: begin
               banner_visible_q <= 1'b0;
            end
            default: begin
               state_q <= S_DONE;
            end
         endcase
      end
   end

   assign origin_x       = origin_x_q;
   assign origin_y       = origin_y_q;
   assign banner_visible = banner_visible_q;
   assign prompt_visible = prompt_visible_q;
   assign title_done     = title_done_q;

endmodule
